// File: rtl/rca_sum_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// rca_pkg
//   Definitions shared by the RCA sum accumulator and the adder bench:
//   the accumulator state encoding, the default adder width / block size,
//   and the sizing helpers for the running total and the sample counter.
// ---------------------------------------------------------------------------
package rca_pkg;

  // Adder operand width and samples per block used by default.
  localparam int DEF_WIDTH = 4;
  localparam int DEF_COUNT = 4;

  // ACCUM: collecting samples of a block.  HOLD: completed block on output.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // A sum of COUNT values, each WIDTH+1 bits wide, needs $clog2(COUNT)
  // extra bits of headroom, so the total never overflows.
  function automatic int acc_width(input int width, input int count);
    return width + 1 + $clog2(count);
  endfunction

  // Sample counter width; COUNT >= 2 keeps this at one bit or more.
  function automatic int cnt_width(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage : rca_pkg

// File: rtl/rca_sum_accumulator.sv
// ---------------------------------------------------------------------------
// rca_sum_accumulator
//   Consumes the registered sum of the ripple-carry adder one sample per
//   valid/ready transfer, accumulates blocks of COUNT samples and presents
//   each block's total and largest sample on a valid/ready output port.
//   The total is kept at full width, so it can never overflow.
//
// Parameters
//   WIDTH  adder operand width; samples are WIDTH+1 bits (COUNT must be >= 2)
//   COUNT  samples per block
//   ACC_W  width of the block total (derived)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   clr         synchronous clear: drops the partial block / pending result
//   in_sum      sample from the adder
//   in_valid    in_sum valid this cycle
//   in_ready    accumulator accepts a sample this cycle (ACCUM state)
//   out_total   total of the last completed block
//   out_max     largest sample of the last completed block
//   out_blocks  completed blocks handed off, wraps 255 -> 0
//   out_valid   out_total/out_max hold a block waiting for the sink (HOLD)
//   out_ready   sink accepts the result this cycle
// ---------------------------------------------------------------------------
module rca_sum_accumulator
  import rca_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int COUNT = DEF_COUNT,
  localparam int ACC_W = acc_width(WIDTH, COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH:0]   in_sum,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [WIDTH:0]   out_max,
  output logic [7:0]       out_blocks,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  acc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [WIDTH:0]   r_max;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_out_total;
  logic [WIDTH:0]   r_out_max;
  logic [7:0]       r_out_blocks;

  logic             w_accept;
  logic             w_last;
  logic             w_xfer;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [WIDTH:0]   w_max_nxt;

  // Handshake decode. clr overrides both transfers, but in_ready/out_valid
  // still reflect the current state so the ports never glitch on clr.
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);

  assign w_accept  = in_ready && in_valid && !clr;
  assign w_last    = w_accept && (r_cnt == LAST_CNT);
  assign w_xfer    = out_valid && out_ready && !clr;

  // Running values including the sample being accepted this cycle; the
  // last sample of a block goes straight into the result registers.
  assign w_acc_nxt = r_acc + ACC_W'(in_sum);
  assign w_max_nxt = (in_sum > r_max) ? in_sum : r_max;

  // Block FSM: ACCUM until the COUNT-th sample, HOLD until the sink takes
  // the result. No bypass back to accepting in the transfer cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ACCUM;
    end else if (clr) begin
      r_state <= ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_last) r_state <= HOLD;
        HOLD:    if (w_xfer) r_state <= ACCUM;
        default: r_state <= ACCUM;
      endcase
    end
  end

  // Accumulator, result and block-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc        <= '0;
      r_max        <= '0;
      r_cnt        <= '0;
      r_out_total  <= '0;
      r_out_max    <= '0;
      r_out_blocks <= '0;
    end else if (clr) begin
      // Partial block discarded; the last delivered result stays visible.
      r_acc <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else begin
      if (w_last) begin
        r_out_total <= w_acc_nxt;
        r_out_max   <= w_max_nxt;
        r_acc       <= '0;
        r_max       <= '0;
        r_cnt       <= '0;
      end else if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_max <= w_max_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_xfer) begin
        r_out_blocks <= r_out_blocks + 8'd1;
      end
    end
  end

  assign out_total  = r_out_total;
  assign out_max    = r_out_max;
  assign out_blocks = r_out_blocks;

endmodule : rca_sum_accumulator
